// File: rtl/change_return_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module   : change_return_sequencer_pkg
// Purpose  : Shared widths and state encoding for the change-return sequencer.
//            kNumCoins  - number of coin denominations
//            kTotalBits - width of every balance/remainder quantity
//            state_e    - sequencer states (IDLE, DISPENSE, DONE)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package change_return_sequencer_pkg;

  localparam int kNumCoins  = 3;
  localparam int kTotalBits = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_DONE     = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/change_return_sequencer_greedy_coin_select.sv
//------------------------------------------------------------------------------
// Module   : change_return_sequencer_greedy_coin_select
// Purpose  : Combinational greedy picker. Returns the largest coin whose value
//            does not exceed the remaining balance, as a one-hot vector plus
//            that coin's value. Both outputs are zero when no coin fits.
// Ports    : remaining [kTotalBits]  balance still to be returned
//            coin      [kNumCoins]   one-hot selected coin (0 = none fits)
//            value     [kTotalBits]  value of the selected coin (0 = none)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module change_return_sequencer_greedy_coin_select
  import change_return_sequencer_pkg::*;
#(
  parameter int COIN_VAL0 = 100,
  parameter int COIN_VAL1 = 500,
  parameter int COIN_VAL2 = 1000
) (
  input  logic [kTotalBits-1:0] remaining,
  output logic [kNumCoins-1:0]  coin,
  output logic [kTotalBits-1:0] value
);

  localparam logic [kTotalBits-1:0] c_val0 = kTotalBits'(COIN_VAL0);
  localparam logic [kTotalBits-1:0] c_val1 = kTotalBits'(COIN_VAL1);
  localparam logic [kTotalBits-1:0] c_val2 = kTotalBits'(COIN_VAL2);

  // Priority order from the largest denomination down gives the greedy choice.
  always_comb begin
    coin  = '0;
    value = '0;
    if (remaining >= c_val2) begin
      coin  = 3'b100;
      value = c_val2;
    end else if (remaining >= c_val1) begin
      coin  = 3'b010;
      value = c_val1;
    end else if (remaining >= c_val0) begin
      coin  = 3'b001;
      value = c_val0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/change_return_sequencer.sv
//------------------------------------------------------------------------------
// Module   : change_return_sequencer
// Purpose  : Sequential change dispenser. On a return request (trigger or
//            expired wait timer) with a nonzero balance, latches the balance
//            and emits one coin per cycle, largest denomination first, until
//            the remainder is smaller than the smallest coin.
// Ports    : clk              system clock, rising edge
//            reset_n          asynchronous active-low reset
//            i_trigger_return user return request (level)
//            i_wait_time      wait timer value, 0 means expired
//            i_current_total  balance, sampled only at start
//            o_return_coin    registered one-hot coin emitted this cycle
//            o_busy           high in any state other than IDLE
//            o_done           high for the single DONE cycle
//            o_residue        undispensed remainder, valid from DONE onward
//            o_coin_count     (CHANGE_AUDIT_EN only) 16-bit saturating
//                             per-denomination coin counters, coin k at
//                             bits [16k+15:16k]
// Options  : define CHANGE_AUDIT_EN to add o_coin_count and its counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module change_return_sequencer
  import change_return_sequencer_pkg::*;
#(
  parameter int COIN_VAL0 = 100,
  parameter int COIN_VAL1 = 500,
  parameter int COIN_VAL2 = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_trigger_return,
  input  logic [31:0]           i_wait_time,
  input  logic [kTotalBits-1:0] i_current_total,
  output logic [kNumCoins-1:0]  o_return_coin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [kTotalBits-1:0] o_residue
`ifdef CHANGE_AUDIT_EN
  ,
  output logic [kNumCoins*16-1:0] o_coin_count
`endif
);

  localparam logic [kTotalBits-1:0] c_coin_min = kTotalBits'(COIN_VAL0);

  // Greedy selection is only correct for nonzero, strictly ascending values.
  if (!(COIN_VAL0 > 0 && COIN_VAL1 > COIN_VAL0 && COIN_VAL2 > COIN_VAL1))
  begin : g_coin_value_check
    $error("change_return_sequencer: coin values must be nonzero and strictly ascending");
  end

  state_e                state_q, state_d;
  logic [kTotalBits-1:0] remaining_q, remaining_d;
  logic [kNumCoins-1:0]  coin_d;
  logic [kTotalBits-1:0] residue_d;
  logic [kNumCoins-1:0]  sel_coin;
  logic [kTotalBits-1:0] sel_value;
  logic [kTotalBits-1:0] remaining_after;
  logic                  start;

  change_return_sequencer_greedy_coin_select #(
    .COIN_VAL0 (COIN_VAL0),
    .COIN_VAL1 (COIN_VAL1),
    .COIN_VAL2 (COIN_VAL2)
  ) u_select (
    .remaining (remaining_q),
    .coin      (sel_coin),
    .value     (sel_value)
  );

  assign start = (i_trigger_return || (i_wait_time == 32'd0)) &&
                 (i_current_total != '0);

  // Cannot underflow: sel_value is either 0 or a coin no larger than remaining.
  assign remaining_after = remaining_q - sel_value;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_d      = '0;
    residue_d   = o_residue;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = i_current_total;
          state_d     = ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        if (sel_coin != '0) begin
          coin_d      = sel_coin;
          remaining_d = remaining_after;
          // Publish the residue on entry to DONE so it is valid alongside o_done.
          if (remaining_after < c_coin_min) begin
            state_d   = ST_DONE;
            residue_d = remaining_after;
          end
        end else begin
          state_d   = ST_DONE;
          residue_d = remaining_q;
        end
      end
      ST_DONE: begin
        residue_d = remaining_q;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      remaining_q   <= '0;
      o_return_coin <= '0;
      o_residue     <= '0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      o_return_coin <= coin_d;
      o_residue     <= residue_d;
    end
  end

  assign o_busy = (state_q != ST_IDLE);
  assign o_done = (state_q == ST_DONE);

`ifdef CHANGE_AUDIT_EN
  // Counters advance on the same edge that registers the coin bit high.
  for (genvar k = 0; k < kNumCoins; k++) begin : g_audit
    logic [15:0] count;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        count <= '0;
      end else if (coin_d[k] && (count != 16'hFFFF)) begin
        count <= count + 16'd1;
      end
    end
    assign o_coin_count[k*16 +: 16] = count;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_change_return_sequencer.sv
`default_nettype none

module tb_change_return_sequencer;
  import change_return_sequencer_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  i_trigger_return;
  logic [31:0]           i_wait_time;
  logic [kTotalBits-1:0] i_current_total;
  logic [kNumCoins-1:0]  o_return_coin;
  logic                  o_busy;
  logic                  o_done;
  logic [kTotalBits-1:0] o_residue;
`ifdef CHANGE_AUDIT_EN
  logic [kNumCoins*16-1:0] o_coin_count;
`endif

  always #5 clk = ~clk;

  change_return_sequencer #(
    .COIN_VAL0 (100),
    .COIN_VAL1 (500),
    .COIN_VAL2 (1000)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_trigger_return (i_trigger_return),
    .i_wait_time      (i_wait_time),
    .i_current_total  (i_current_total),
    .o_return_coin    (o_return_coin),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_residue        (o_residue)
`ifdef CHANGE_AUDIT_EN
    ,
    .o_coin_count     (o_coin_count)
`endif
  );

  typedef struct packed {
    logic                  is_done;
    logic [kNumCoins-1:0]  coin;
    logic [kTotalBits-1:0] residue;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   model_count [kNumCoins];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_coin(input logic [kNumCoins-1:0] c);
    exp_t e;
    e.is_done = 1'b0;
    e.coin    = c;
    e.residue = '0;
    exp_q.push_back(e);
    for (int k = 0; k < kNumCoins; k++) if (c[k]) model_count[k]++;
  endtask

  task automatic expect_done(input logic [kTotalBits-1:0] r);
    exp_t e;
    e.is_done = 1'b1;
    e.coin    = '0;
    e.residue = r;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic is_done, input logic [kNumCoins-1:0] c,
                           input logic [kTotalBits-1:0] r);
    exp_t e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL unexpected_output: actual done=%0d coin=%b residue=%0d required nothing (t=%0t)",
               is_done, c, r, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind(1=done)", 32'(is_done), 32'(e.is_done));
      if (is_done == e.is_done) begin
        if (is_done) check("done_residue", 32'(r), 32'(e.residue));
        else         check("coin", 32'(c), 32'(e.coin));
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a coin or o_done.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      check("coin_onehot0", 32'($onehot0(o_return_coin)), 32'd1);
      if (o_return_coin != '0) pop_check(1'b0, o_return_coin, '0);
      if (o_done)              pop_check(1'b1, '0, o_residue);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!o_busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(name, 32'(ok), 32'd1);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    for (int k = 0; k < kNumCoins; k++) model_count[k] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < kNumCoins; k++) model_count[k] = 0;
    reset_n          = 1'b0;
    i_trigger_return = 1'b0;
    i_wait_time      = 32'd100;
    i_current_total  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_coin",    32'(o_return_coin), 32'd0);
    check("reset_busy",    32'(o_busy),        32'd0);
    check("reset_done",    32'(o_done),        32'd0);
    check("reset_residue", 32'(o_residue),     32'd0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    // 1600 by trigger pulse: 1000, 500, 100, then done with residue 0.
    expect_coin(3'b100); expect_coin(3'b010); expect_coin(3'b001); expect_done(16'd0);
    i_current_total = 16'd1600; i_trigger_return = 1'b1;
    tick();                                   // E0
    i_trigger_return = 1'b0;
    check("t1_busy_after_start", 32'(o_busy), 32'd1);
    check("t1_no_coin_at_E0",    32'(o_return_coin), 32'd0);
    tick();                                   // E1
    check("t1_first_coin_E1",    32'(o_return_coin), 32'd4);
    tick(); tick();                           // E3
    check("t1_done_at_E3",       32'(o_done), 32'd1);
    check("t1_residue_at_done",  32'(o_residue), 32'd0);
    tick();                                   // E4
    check("t1_idle_at_E4",       32'(o_busy), 32'd0);
    check("t1_done_one_cycle",   32'(o_done), 32'd0);

    // 700 by expired wait timer.
    expect_coin(3'b010); expect_coin(3'b001); expect_coin(3'b001); expect_done(16'd0);
    i_current_total = 16'd700; i_wait_time = 32'd0;
    tick();
    i_wait_time = 32'd100;
    wait_idle("t2_timeout");

    // 50: nothing fits, done one cycle after the start edge, residue 50.
    expect_done(16'd50);
    i_current_total = 16'd50; i_trigger_return = 1'b1;
    tick();
    i_trigger_return = 1'b0;
    check("t3_no_done_at_E0", 32'(o_done), 32'd0);
    tick();
    check("t3_done_at_E1",    32'(o_done), 32'd1);
    check("t3_residue",       32'(o_residue), 32'd50);
    check("t3_no_coin",       32'(o_return_coin), 32'd0);
    wait_idle("t3_timeout");

    // 1600 with reset after the first coin: output stops at once, no done.
    expect_coin(3'b100);
    i_current_total = 16'd1600; i_trigger_return = 1'b1;
    tick();
    i_trigger_return = 1'b0;
    tick();                                   // first coin visible
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    for (int k = 0; k < kNumCoins; k++) model_count[k] = 0;
    #1;
    check("t4_reset_coin_now", 32'(o_return_coin), 32'd0);
    check("t4_reset_busy_now", 32'(o_busy), 32'd0);
    check("t4_reset_residue",  32'(o_residue), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) tick();
    check("t4_stays_idle", 32'(o_busy), 32'd0);

    // 1500 with trigger held and total changed mid-dispense: no restart.
    expect_coin(3'b100); expect_coin(3'b010); expect_done(16'd0);
    i_current_total = 16'd1500; i_trigger_return = 1'b1;
    tick();
    i_current_total = 16'd3000;
    tick(); tick();                           // E2: second coin, state DONE
    i_trigger_return = 1'b0;
    wait_idle("t5_timeout");

    // Back-to-back: trigger held across DONE restarts in the following cycle.
    expect_coin(3'b010); expect_coin(3'b001); expect_done(16'd0);
    expect_coin(3'b100); expect_done(16'd0);
    i_current_total = 16'd600; i_trigger_return = 1'b1;
    tick();
    i_current_total = 16'd1000;
    repeat (4) tick();                        // E4: restart edge
    i_trigger_return = 1'b0;
    check("t6_restarted", 32'(o_busy), 32'd1);
    wait_idle("t6_timeout");

    // 1550: leaves residue 50.
    expect_coin(3'b100); expect_coin(3'b010); expect_done(16'd50);
    i_current_total = 16'd1550; i_trigger_return = 1'b1;
    tick();
    i_trigger_return = 1'b0;
    wait_idle("t7_timeout");

    // 1700 by wait timer: 1000, 500, 100, 100.
    expect_coin(3'b100); expect_coin(3'b010); expect_coin(3'b001); expect_coin(3'b001);
    expect_done(16'd0);
    i_current_total = 16'd1700; i_wait_time = 32'd0;
    tick();
    i_wait_time = 32'd100;
    wait_idle("t8_timeout");

    // Three returns of 1600 from a fresh reset.
    do_reset();
    for (int n = 0; n < 3; n++) begin
      expect_coin(3'b100); expect_coin(3'b010); expect_coin(3'b001); expect_done(16'd0);
      i_current_total = 16'd1600; i_trigger_return = 1'b1;
      tick();
      i_trigger_return = 1'b0;
      wait_idle("t9_timeout");
    end
`ifdef CHANGE_AUDIT_EN
    for (int k = 0; k < kNumCoins; k++)
      check($sformatf("audit_count[%0d]", k), 32'(o_coin_count[k*16 +: 16]),
            32'(model_count[k]));
`endif

    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
